// File: rtl/fpu_host_pkg.sv
// Shared types and constants for the FPU host-side bus master.
package fpu_host_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned HALF_W = 16;
    localparam int unsigned EXC_W  = 3;

    localparam logic OPT_ADD = 1'b0;
    localparam logic OPT_MUL = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StWaitFree,
        StSendA,
        StSendB,
        StWaitRes,
        StRxHi,
        StRxLo,
        StResp
    } fpu_host_state_e;

endpackage

// File: rtl/fpu_host_wdog.sv
// Per-phase watchdog for fpu_host_master; only instantiated with FPU_HOST_TIMEOUT_EN.
module fpu_host_wdog #(
    parameter int unsigned Cycles = 1024
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int unsigned CntW = (Cycles > 2) ? $clog2(Cycles) : 1;

    logic [CntW-1:0] cnt_q;

    // clr marks the first cycle of a phase, so that cycle is already spent on load.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= CntW'(Cycles - 2);
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CntW'(1);
        end
    end

    assign expire = en && !clr && (cnt_q == '0);

endmodule

// File: rtl/fpu_host_master.sv
// Host initiator for the FPU command/result bus, one operation outstanding.
// Define FPU_HOST_TIMEOUT_EN to add the per-phase watchdog abort (res_err).
module fpu_host_master
    import fpu_host_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_opt,
    input  logic [2:0]        cmd_mode,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [EXC_W-1:0]  res_exc,
    output logic              res_opt,
    output logic              res_err,
    output logic              CS,
    output logic              DIV,
    output logic [DATA_W-1:0] DIN,
    output logic              OPT,
    output logic [2:0]        MODE,
    output logic              DOA,
    input  logic              DACK,
    input  logic              DR,
    input  logic              DOV,
    input  logic              ABUSY,
    input  logic              MBUSY,
    input  logic [HALF_W-1:0] DOUT,
    input  logic [EXC_W-1:0]  EXC
);

    fpu_host_state_e   state_q;
    logic [DATA_W-1:0] a_q, b_q;
    logic              wd_clr;
    logic              wd_expire;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= StIdle;
            a_q       <= '0;
            b_q       <= '0;
            wd_clr    <= 1'b0;
            cmd_ready <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_exc   <= '0;
            res_opt   <= 1'b0;
            res_err   <= 1'b0;
            CS        <= 1'b0;
            DIV       <= 1'b0;
            DIN       <= '0;
            OPT       <= 1'b0;
            MODE      <= '0;
            DOA       <= 1'b0;
        end else begin
            wd_clr <= 1'b0;
            if (wd_expire) begin
                CS        <= 1'b0;
                DIV       <= 1'b0;
                DOA       <= 1'b0;
                res_valid <= 1'b1;
                res_err   <= 1'b1;
                res_data  <= '0;
                res_exc   <= '0;
                res_opt   <= OPT;
                wd_clr    <= 1'b1;
                state_q   <= StResp;
            end else begin
                case (state_q)
                    StIdle: begin
                        cmd_ready <= 1'b1;
                        if (cmd_valid && cmd_ready) begin
                            a_q       <= cmd_a;
                            b_q       <= cmd_b;
                            OPT       <= cmd_opt;
                            MODE      <= cmd_mode;
                            CS        <= 1'b1;
                            cmd_ready <= 1'b0;
                            wd_clr    <= 1'b1;
                            state_q   <= StWaitFree;
                        end
                    end
                    StWaitFree: begin
                        if (!((OPT == OPT_MUL) ? MBUSY : ABUSY)) begin
                            DIV     <= 1'b1;
                            DIN     <= a_q;
                            wd_clr  <= 1'b1;
                            state_q <= StSendA;
                        end
                    end
                    StSendA: begin
                        DIN     <= b_q;
                        wd_clr  <= 1'b1;
                        state_q <= StSendB;
                    end
                    StSendB: begin
                        if (DACK) begin
                            DIV     <= 1'b0;
                            wd_clr  <= 1'b1;
                            state_q <= StWaitRes;
                        end
                    end
                    StWaitRes: begin
                        if (DOV) begin
                            res_data[DATA_W-1:HALF_W] <= DOUT;
                            DOA     <= 1'b1;
                            wd_clr  <= 1'b1;
                            state_q <= StRxHi;
                        end
                    end
                    // RX_LO is never entered; treated as RX_HI for safety.
                    StRxHi, StRxLo: begin
                        DOA    <= 1'b0;
                        wd_clr <= 1'b1;
                        if (DOV) begin
                            res_data[HALF_W-1:0] <= DOUT;
                            res_exc   <= EXC;
                            res_opt   <= OPT;
                            res_err   <= 1'b0;
                            res_valid <= 1'b1;
                            CS        <= 1'b0;
                            state_q   <= StResp;
                        end else begin
                            res_data[DATA_W-1:HALF_W] <= '0;
                            state_q <= StWaitRes;
                        end
                    end
                    StResp: begin
                        if (res_ready) begin
                            res_valid <= 1'b0;
                            res_err   <= 1'b0;
                            cmd_ready <= 1'b1;
                            wd_clr    <= 1'b1;
                            state_q   <= StIdle;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

`ifdef FPU_HOST_TIMEOUT_EN
    logic wd_en;
    assign wd_en = (state_q == StWaitFree) || (state_q == StSendB) || (state_q == StWaitRes);

    fpu_host_wdog #(
        .Cycles(TIMEOUT_CYCLES)
    ) u_wdog (
        .CLK   (CLK),
        .RST   (RST),
        .clr   (wd_clr),
        .en    (wd_en),
        .expire(wd_expire)
    );

    logic unused_dr;
    assign unused_dr = DR;
`else
    assign wd_expire = 1'b0;

    logic unused_sig;
    assign unused_sig = ^{DR, wd_clr, TIMEOUT_CYCLES[0]};
`endif

endmodule

// File: tb/tb_fpu_host_master.sv
// Directed, table-driven bench for fpu_host_master with a cycle-scripted FPU model.
module tb_fpu_host_master;

    logic        CLK, RST;
    logic        cmd_valid, cmd_ready, cmd_opt;
    logic [2:0]  cmd_mode;
    logic [31:0] cmd_a, cmd_b;
    logic        res_valid, res_ready;
    logic [31:0] res_data;
    logic [2:0]  res_exc;
    logic        res_opt, res_err;
    logic        CS, DIV, OPT, DOA;
    logic [31:0] DIN;
    logic [2:0]  MODE;
    logic        DACK, DR, DOV, ABUSY, MBUSY;
    logic [15:0] DOUT;
    logic [2:0]  EXC;

    int n_checks = 0;
    int n_errors = 0;
    int div_cnt = 0;
    int doa_cnt = 0;

`ifdef FPU_HOST_TIMEOUT_EN
    localparam int MulBusy = 12;
`else
    localparam int MulBusy = 20;
`endif

    typedef struct {
        logic        opt;
        logic [2:0]  mode;
        logic [31:0] a;
        logic [31:0] b;
        logic [15:0] hi;
        logic [15:0] lo;
        logic [2:0]  exc;
        logic [31:0] exp_data;
        int          busy;
        bit          other_busy;
        int          dly;
        int          lat;
        int          rdy;
        bit          rst_mid;
    } vec_t;

    vec_t vecs[7];

    fpu_host_master #(
        .TIMEOUT_CYCLES(16)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_opt  (cmd_opt),
        .cmd_mode (cmd_mode),
        .cmd_a    (cmd_a),
        .cmd_b    (cmd_b),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data (res_data),
        .res_exc  (res_exc),
        .res_opt  (res_opt),
        .res_err  (res_err),
        .CS       (CS),
        .DIV      (DIV),
        .DIN      (DIN),
        .OPT      (OPT),
        .MODE     (MODE),
        .DOA      (DOA),
        .DACK     (DACK),
        .DR       (DR),
        .DOV      (DOV),
        .ABUSY    (ABUSY),
        .MBUSY    (MBUSY),
        .DOUT     (DOUT),
        .EXC      (EXC)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (DIV) div_cnt <= div_cnt + 1;
        if (DOA) doa_cnt <= doa_cnt + 1;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish, required finish before 100us");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic all_zero();
        return ~|{cmd_ready, res_valid, res_data, res_exc, res_opt, res_err,
                  CS, DIV, DIN, OPT, MODE, DOA};
    endfunction

    task automatic run_op(input vec_t v);
        int n, k, div0, doa0;
        n = 0;
        while (!cmd_ready && n < 10) begin
            @(negedge CLK);
            n++;
        end
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_opt   = v.opt;
        cmd_mode  = v.mode;
        cmd_a     = v.a;
        cmd_b     = v.b;
        if (v.opt) begin
            MBUSY = (v.busy > 0);
            ABUSY = v.other_busy;
        end else begin
            ABUSY = (v.busy > 0);
            MBUSY = v.other_busy;
        end
        div0 = div_cnt;
        doa0 = doa_cnt;
        @(negedge CLK);
        k = 0;
        cmd_valid = 1'b0;
        chk("accept", 32'({CS, DIV, DOA, cmd_ready, OPT, MODE}), 32'({4'b1000, v.opt, v.mode}));
        for (int i = 0; i < v.busy; i++) begin
            chk("wait_free", 32'({CS, DIV}), 32'b10);
            @(negedge CLK);
            k++;
        end
        if (v.opt) MBUSY = 1'b0;
        else ABUSY = 1'b0;
        @(negedge CLK);
        k++;
        chk("send_a", 32'(DIV), 32'd1);
        chk("send_a_din", DIN, v.a);
        @(negedge CLK);
        k++;
        for (int i = 0; i < v.dly; i++) begin
            chk("send_b", 32'({DIV, DIN == v.b}), 32'b11);
            if (i == v.dly - 1) DACK = 1'b1;
            @(negedge CLK);
            k++;
        end
        DACK = 1'b0;
        chk("div_drop", 32'({CS, DIV, DOA}), 32'b100);
        if (v.rst_mid) begin
            #2 RST = 1'b1;
            #1 chk("rst_mid_zero", 32'(all_zero()), 32'd1);
            @(negedge CLK);
            RST   = 1'b0;
            ABUSY = 1'b0;
            MBUSY = 1'b0;
            @(negedge CLK);
            chk("rst_mid_noresp", 32'({res_valid, cmd_ready}), 32'b01);
            return;
        end
        for (int i = 0; i < v.lat; i++) begin
            chk("wait_res", 32'({CS, DOA, res_valid}), 32'b100);
            @(negedge CLK);
            k++;
        end
        DOV  = 1'b1;
        DOUT = v.hi;
        @(negedge CLK);
        k++;
        chk("rx_hi", 32'({CS, DOA, res_valid}), 32'b110);
        DOUT = v.lo;
        EXC  = v.exc;
        @(negedge CLK);
        k++;
        DOV  = 1'b0;
        DOUT = '0;
        EXC  = '0;
        chk("resp", 32'({CS, DOA, res_valid, cmd_ready}), 32'b0010);
        chk("latency", 32'(k), 32'(v.busy + v.dly + v.lat + 4));
        chk("res_data", res_data, v.exp_data);
        chk("res_fields", 32'({res_exc, res_opt, res_err}), 32'({v.exc, v.opt, 1'b0}));
        chk("doa_pulses", 32'(doa_cnt - doa0), 32'd1);
        chk("div_pulses", 32'(div_cnt - div0), 32'(v.dly + 1));
        for (int i = 0; i < v.rdy; i++) begin
            chk("resp_hold", 32'({res_valid, cmd_ready, res_data == v.exp_data}), 32'b101);
            @(negedge CLK);
        end
        res_ready = 1'b1;
        @(negedge CLK);
        res_ready = 1'b0;
        chk("handshake", 32'({res_valid, cmd_ready}), 32'b01);
        ABUSY = 1'b0;
        MBUSY = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b0, 3'd0, 32'h3F800000, 32'h40000000, 16'h4040, 16'h0000, 3'b000,
                    32'h40400000, 0, 1'b0, 1, 2, 0, 1'b0};
        vecs[1] = '{1'b1, 3'd1, 32'h40400000, 32'h40800000, 16'h4140, 16'h0000, 3'b000,
                    32'h41400000, MulBusy, 1'b0, 1, 3, 0, 1'b0};
        vecs[2] = '{1'b0, 3'd3, 32'h12345678, 32'h9ABCDEF0, 16'hACAC, 16'h5A5A, 3'b001,
                    32'hACAC5A5A, 0, 1'b0, 5, 1, 0, 1'b0};
        vecs[3] = '{1'b1, 3'd4, 32'h7F000000, 32'h7F000000, 16'h7F80, 16'h0001, 3'b010,
                    32'h7F800001, 0, 1'b0, 1, 4, 10, 1'b0};
        vecs[4] = '{1'b0, 3'd2, 32'h00000001, 32'h80000001, 16'h8000, 16'hFFFF, 3'b100,
                    32'h8000FFFF, 2, 1'b1, 2, 0, 0, 1'b0};
        vecs[5] = '{1'b0, 3'd7, 32'hDEADBEEF, 32'hCAFEF00D, 16'h1111, 16'h2222, 3'b000,
                    32'h11112222, 0, 1'b0, 1, 0, 0, 1'b1};
        vecs[6] = '{1'b1, 3'd5, 32'hC0000000, 32'h3F000000, 16'hBF80, 16'h0000, 3'b000,
                    32'hBF800000, 1, 1'b0, 3, 0, 0, 1'b0};

        RST = 1'b1;
        cmd_valid = 1'b0; cmd_opt = 1'b0; cmd_mode = '0; cmd_a = '0; cmd_b = '0;
        res_ready = 1'b0;
        DACK = 1'b0; DR = 1'b0; DOV = 1'b0; ABUSY = 1'b0; MBUSY = 1'b0;
        DOUT = '0; EXC = '0;
        repeat (3) @(negedge CLK);
        chk("reset_zero", 32'(all_zero()), 32'd1);
        RST = 1'b0;
        @(negedge CLK);
        chk("reset_ready", 32'({cmd_ready, res_valid, CS}), 32'b100);

        for (int v = 0; v < 7; v++) run_op(vecs[v]);

`ifdef FPU_HOST_TIMEOUT_EN
        while (!cmd_ready) @(negedge CLK);
        cmd_valid = 1'b1;
        cmd_opt   = 1'b0;
        cmd_mode  = 3'd6;
        cmd_a     = 32'h01020304;
        cmd_b     = 32'h05060708;
        @(negedge CLK);
        cmd_valid = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        DACK = 1'b1;
        @(negedge CLK);
        DACK = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("to_wait", 32'({CS, res_valid}), 32'b10);
            @(negedge CLK);
        end
        chk("to_resp", 32'({CS, DIV, DOA, res_valid, res_err}), 32'b00011);
        chk("to_data", res_data, 32'h0);
        res_ready = 1'b1;
        @(negedge CLK);
        res_ready = 1'b0;
        chk("to_handshake", 32'({res_valid, res_err, cmd_ready}), 32'b001);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
